vga_timing_controller: RTL

Sequences the VGA output datapath: generates horizontal/vertical timing, requests pixels from an upstream pixel source, and drives HSync, VSync, Red, Green and Blue at the pins. Sits between the frame buffer/pixel generator and the VGA output interface. All pin outputs are registered so the monitor samples stable values at posedge clk.

---
 rtl/vga_timing_controller.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_controller.sv
// -----------------------------------------------------------------------------
// vga_timing_controller
//
// Generates VGA horizontal/vertical timing, requests pixels from an upstream
// source, and drives registered sync and colour pins. Counter position n is
// requested in cycle n. The source answers in cycle n+1, and the pins show the
// result from cycle n+2 onwards. HSync, VSync and RGB all have the same
// 2-clock latency, so they stay aligned at the connector.
//
// Optional feature (compile-time macro VGA_TEST_PATTERN_EN):
//   Adds input pattern_sel. When it is high, the block drives eight vertical
//   colour bars and issues no pixel requests.
//
// Ports:
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   en                timing enable; low parks the counters at (0,0)
//   pix_req           request pixel (pix_x, pix_y) this cycle
//   pix_x, pix_y      raw horizontal / vertical counters
//   pix_valid         source data valid, one cycle after pix_req
//   pix_r/g/b         source colour
//   HSync, VSync      registered sync pins (polarity set by SYNC_ACTIVE_HIGH)
//   Red/Green/Blue    registered colour pins, forced to 0 while blanking
//   frame_start       pulse at counter (0,0) while enabled (not delayed)
//   underflow         pulse aligned with a pin pixel the source missed
//   underflow_cnt     saturating count of missed pixels
//   pattern_sel       (VGA_TEST_PATTERN_EN only) select colour-bar pattern
// -----------------------------------------------------------------------------
module vga_timing_controller #(
  parameter int COLOR_WIDTH      = 4,
  parameter int H_VISIBLE        = 640,
  parameter int H_FRONT          = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BACK           = 48,
  parameter int V_VISIBLE        = 480,
  parameter int V_FRONT          = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BACK           = 33,
  parameter int SYNC_ACTIVE_HIGH = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                   pattern_sel,
`endif
  output logic                   pix_req,
  output logic [$clog2(H_VISIBLE+H_FRONT+H_SYNC+H_BACK)-1:0] pix_x,
  output logic [$clog2(V_VISIBLE+V_FRONT+V_SYNC+V_BACK)-1:0] pix_y,
  input  logic                   pix_valid,
  input  logic [COLOR_WIDTH-1:0] pix_r,
  input  logic [COLOR_WIDTH-1:0] pix_g,
  input  logic [COLOR_WIDTH-1:0] pix_b,
  output logic                   HSync,
  output logic                   VSync,
  output logic [COLOR_WIDTH-1:0] Red,
  output logic [COLOR_WIDTH-1:0] Green,
  output logic [COLOR_WIDTH-1:0] Blue,
  output logic                   frame_start,
  output logic                   underflow,
  output logic [15:0]            underflow_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic          SYNC_ON = (SYNC_ACTIVE_HIGH != 0);

  // Both axes step through the same four regions in the same order.
  typedef enum logic [1:0] {
    R_ACTIVE,
    R_FRONT,
    R_SYNC,
    R_BACK
  } region_e;

  function automatic region_e region_of(input int cnt, input int vis,
                                        input int front, input int sync);
    if (cnt < vis)                     return R_ACTIVE;
    else if (cnt < vis + front)        return R_FRONT;
    else if (cnt < vis + front + sync) return R_SYNC;
    else                               return R_BACK;
  endfunction

  // Counter stage
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  region_e       h_state, v_state;
  logic          line_active;

  // Stage 1: flags delayed to line up with the source's reply
  logic act1_q, act1_d;
  logic hs1_q,  hs1_d;
  logic vs1_q,  vs1_d;
`ifdef VGA_TEST_PATTERN_EN
  logic       pat1_q, pat1_d;
  logic [2:0] bar1_q, bar1_d;
`endif

  // Stage 2: pin registers
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic [COLOR_WIDTH-1:0] red_q,   red_d;
  logic [COLOR_WIDTH-1:0] green_q, green_d;
  logic [COLOR_WIDTH-1:0] blue_q,  blue_d;
  logic                   underflow_q, underflow_d;
  logic [15:0]            ufl_cnt_q,   ufl_cnt_d;

  // ---------------------------------------------------------------------------
  // Counter stage and region decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave
    // it unassigned. An unassigned path would infer a latch.
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!en) begin
      // Park at (0,0) so that re-enabling starts a fresh frame immediately.
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end else begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
  end

  always_comb begin
    h_state     = region_of(int'(h_cnt_q), H_VISIBLE, H_FRONT, H_SYNC);
    v_state     = region_of(int'(v_cnt_q), V_VISIBLE, V_FRONT, V_SYNC);
    line_active = en && (h_state == R_ACTIVE) && (v_state == R_ACTIVE);

    act1_d = line_active;
    hs1_d  = en && (h_state == R_SYNC);
    vs1_d  = en && (v_state == R_SYNC);   // whole lines, from h=0 onwards

    // These outputs come straight from the counters. The rst_n term keeps them
    // low during reset, even when en is already high.
`ifdef VGA_TEST_PATTERN_EN
    pix_req = rst_n && line_active && !pattern_sel;
    pat1_d  = pattern_sel;
    bar1_d  = 3'((int'(h_cnt_q) * 8) / H_VISIBLE);
`else
    pix_req = rst_n && line_active;
`endif
    frame_start = rst_n && en && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // ---------------------------------------------------------------------------
  // Output stage: combine the aligned flags with the source reply
  // ---------------------------------------------------------------------------
  always_comb begin
    hsync_d     = hs1_q ? SYNC_ON : ~SYNC_ON;
    vsync_d     = vs1_q ? SYNC_ON : ~SYNC_ON;
    red_d       = '0;
    green_d     = '0;
    blue_d      = '0;
    underflow_d = 1'b0;

    if (act1_q) begin
`ifdef VGA_TEST_PATTERN_EN
      if (pat1_q) begin
        red_d   = {COLOR_WIDTH{bar1_q[0]}};
        green_d = {COLOR_WIDTH{bar1_q[1]}};
        blue_d  = {COLOR_WIDTH{bar1_q[2]}};
      end else
`endif
      if (pix_valid) begin
        red_d   = pix_r;
        green_d = pix_g;
        blue_d  = pix_b;
      end else begin
        underflow_d = 1'b1;  // missed pixel is shown black
      end
    end

    ufl_cnt_d = ufl_cnt_q;
    if (underflow_d && (ufl_cnt_q != 16'hFFFF))
      ufl_cnt_d = ufl_cnt_q + 16'd1;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      act1_q      <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      pat1_q      <= 1'b0;
      bar1_q      <= '0;
`endif
      hsync_q     <= ~SYNC_ON;
      vsync_q     <= ~SYNC_ON;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      underflow_q <= 1'b0;
      ufl_cnt_q   <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      act1_q      <= act1_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
`ifdef VGA_TEST_PATTERN_EN
      pat1_q      <= pat1_d;
      bar1_q      <= bar1_d;
`endif
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      underflow_q <= underflow_d;
      ufl_cnt_q   <= ufl_cnt_d;
    end
  end

  assign pix_x         = h_cnt_q;
  assign pix_y         = v_cnt_q;
  assign HSync         = hsync_q;
  assign VSync         = vsync_q;
  assign Red           = red_q;
  assign Green         = green_q;
  assign Blue          = blue_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = ufl_cnt_q;

endmodule
